// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and constants: fetch FSM states, NOP encoding, PCSrc encodings
// and the {pc, instr} buffer entry.
package riscv_pkg;

    typedef enum logic [1:0] {
        StBoot  = 2'b00,
        StRun   = 2'b01,
        StFlush = 2'b10
    } fetch_state_e;

    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// FIFO of fetched {pc, instr} entries with synchronous clear; DEPTH must be a power of two.
module fetch_buffer
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  fetch_entry_t             i_entry,
    input  logic                     i_pop,
    output fetch_entry_t             o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(DEPTH);

    fetch_entry_t     r_mem [DEPTH];
    logic [PtrW-1:0]  r_rd_ptr;
    logic [PtrW-1:0]  r_wr_ptr;
    logic [PtrW:0]    r_count;
    logic             w_push;
    logic             w_pop;

    always_comb begin
        w_pop  = i_pop && (r_count != '0);
        w_push = i_push && ((r_count != DepthCnt) || w_pop);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
            if (w_push && !w_pop) begin
                r_count <= r_count + (PtrW + 1)'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - (PtrW + 1)'(1);
            end
        end
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge i_clk) begin
        if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_entry;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == DepthCnt);
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential prefetch into a small FIFO, redirect flush, 2-cycle latency.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);

    localparam int unsigned   CntW     = $clog2(BUF_DEPTH) + 1;
    localparam logic [CntW:0] DepthOcc = (CntW + 1)'(BUF_DEPTH);

    fetch_state_e    r_state;
    fetch_state_e    w_state_next;
    logic [31:0]     r_pc;
    logic [31:0]     r_req_pc;
    logic            r_inflight;
    logic            w_deq;
    logic            w_push;
    logic            w_flush;
    logic            w_issue;
    logic            w_full;
    logic            w_empty;
    logic            w_unused;
    logic [CntW-1:0] w_count;
    logic [CntW:0]   w_occ;
    fetch_entry_t    w_head;
    fetch_entry_t    w_entry;

    always_ff @(posedge clk) begin
        if (rst) r_state <= StBoot;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StBoot:  w_state_next = StRun;
            StRun:   w_state_next = redirect_valid ? StFlush : StRun;
            StFlush: w_state_next = redirect_valid ? StFlush : StRun;
            default: w_state_next = StBoot;
        endcase
    end

    always_comb begin
        w_deq   = !w_empty && instr_ready;
        // Slots committed after this cycle; the response of an issue always lands next cycle.
        w_occ   = {1'b0, w_count} + {{CntW{1'b0}}, r_inflight} - {{CntW{1'b0}}, w_deq};
        w_issue = (r_state != StBoot) && (w_occ < DepthOcc);
        w_flush = redirect_valid && (r_state != StBoot);
        // Responses landing in FLUSH belong to the abandoned path.
        w_push  = r_inflight && (r_state == StRun);
        w_entry.pc    = r_req_pc;
        w_entry.instr = imem_rdata;

        imem_req    = w_issue;
        imem_addr   = r_pc;
        instr_valid = !w_empty;
        instr       = w_empty ? NOP : w_head.instr;
        instr_pc    = w_empty ? 32'h0 : w_head.pc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_req_pc   <= 32'h0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) r_req_pc <= r_pc;
            if (w_flush) begin
                r_pc <= {redirect_pc[31:2], 2'b00};
            end else if (w_issue) begin
                r_pc <= r_pc + 32'd4;
            end
        end
    end

    fetch_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_fetch_buffer (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_flush (w_flush),
        .i_push  (w_push),
        .i_entry (w_entry),
        .i_pop   (w_deq),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Full is already implied by the occupancy check above.
    assign w_unused = ^{redirect_pc[1:0], w_full};

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_fetched <= 32'h0;
            r_perf_stall   <= 32'h0;
        end else begin
            if (w_deq && (r_perf_fetched != 32'hFFFF_FFFF)) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            if (instr_valid && !instr_ready && (r_perf_stall != 32'hFFFF_FFFF)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_stall   = r_perf_stall;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: two instances (different RESET_PC/BUF_DEPTH) against a program-order
// reference model, directed scenarios then random ready/redirect traffic.
module tb_fetch_unit;

    localparam logic [31:0] PC_A    = 32'h0000_0100;
    localparam logic [31:0] PC_B    = 32'hFFFF_FFF8;
    localparam int unsigned DEPTH_A = 2;
    localparam int unsigned DEPTH_B = 4;
    localparam logic [31:0] TB_NOP  = 32'h0000_0013;
    localparam logic [31:0] NO_XFER = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        a_req, b_req, a_valid, b_valid;
    logic [31:0] a_addr, b_addr, a_instr, b_instr, a_pc, b_pc;
    logic [31:0] a_rdata = 32'h0;
    logic [31:0] b_rdata = 32'h0;
`ifdef FETCH_PERF_EN
    logic [31:0] a_pf, a_ps, b_pf, b_ps;
`endif

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(PC_A), .BUF_DEPTH(DEPTH_A)) u_dut_a (
        .clk(clk), .rst(rst), .imem_req(a_req), .imem_addr(a_addr), .imem_rdata(a_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .instr_valid(a_valid),
        .instr_ready(instr_ready), .instr(a_instr), .instr_pc(a_pc)
`ifdef FETCH_PERF_EN
        , .perf_fetched(a_pf), .perf_stall(a_ps)
`endif
    );

    fetch_unit #(.RESET_PC(PC_B), .BUF_DEPTH(DEPTH_B)) u_dut_b (
        .clk(clk), .rst(rst), .imem_req(b_req), .imem_addr(b_addr), .imem_rdata(b_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .instr_valid(b_valid),
        .instr_ready(instr_ready), .instr(b_instr), .instr_pc(b_pc)
`ifdef FETCH_PERF_EN
        , .perf_fetched(b_pf), .perf_stall(b_ps)
`endif
    );

    int          n_checks = 0;
    int          n_fails  = 0;
    logic [31:0] salt;

    // Reference model: the program-order stream each instance should deliver.
    logic [31:0] m_exp_pc [2];
    logic [31:0] m_prev_instr [2];
    logic [31:0] m_prev_ipc [2];
    logic        m_prev_valid [2];
    int          m_xf [2];
    int          m_st [2];
    int          xcnt [2];
    logic [31:0] first_pc [2];
    logic        m_prev_rst, m_prev_ready, m_prev_redirect;
    logic [31:0] m_prev_target;
    int          cyc;

    logic        lg_req [2][64];
    logic        lg_valid [2][64];
    logic [31:0] lg_addr [2][64];
    logic [31:0] lg_pc [2][64];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[31:2], 2'b11} ^ salt;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic rdy, input logic rv, input logic [31:0] rpc);
        logic        req [2];
        logic        val [2];
        logic [31:0] addr [2];
        logic [31:0] ins [2];
        logic [31:0] ipc [2];
`ifdef FETCH_PERF_EN
        logic [31:0] pf [2];
        logic [31:0] ps [2];
`endif
        instr_ready    = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        @(negedge clk);
        req[0] = a_req;   req[1] = b_req;   addr[0] = a_addr;  addr[1] = b_addr;
        val[0] = a_valid; val[1] = b_valid; ins[0] = a_instr;  ins[1] = b_instr;
        ipc[0] = a_pc;    ipc[1] = b_pc;
`ifdef FETCH_PERF_EN
        pf[0] = a_pf; pf[1] = b_pf; ps[0] = a_ps; ps[1] = b_ps;
`endif
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_exp_pc[i]     = (i == 0) ? PC_A : PC_B;
                m_xf[i]         = 0;
                m_st[i]         = 0;
                m_prev_valid[i] = 1'b0;
                first_pc[i]     = NO_XFER;
            end else begin
                if (cyc < 64) begin
                    lg_req[i][cyc] = req[i]; lg_addr[i][cyc] = addr[i];
                    lg_valid[i][cyc] = val[i]; lg_pc[i][cyc] = ipc[i];
                end
                if (m_prev_rst) begin
                    check("reset_imem_req", {31'b0, req[i]}, 32'h0);
                    check("reset_instr_valid", {31'b0, val[i]}, 32'h0);
                    check("reset_instr_nop", ins[i], TB_NOP);
                    check("reset_instr_pc", ipc[i], 32'h0);
                end else if (m_prev_redirect) begin
                    check("flush_valid_low", {31'b0, val[i]}, 32'h0);
                    check("flush_req", {31'b0, req[i]}, 32'h1);
                    check("flush_target_addr", addr[i], m_prev_target);
                end else if (m_prev_valid[i] && !m_prev_ready) begin
                    check("hold_valid", {31'b0, val[i]}, 32'h1);
                    check("hold_instr", ins[i], m_prev_instr[i]);
                    check("hold_pc", ipc[i], m_prev_ipc[i]);
                end
`ifdef FETCH_PERF_EN
                check("perf_fetched", pf[i], m_xf[i]);
                check("perf_stall", ps[i], m_st[i]);
`endif
                if (val[i] && rdy) begin
                    check("xfer_pc", ipc[i], m_exp_pc[i]);
                    check("xfer_instr", ins[i], mem_word(m_exp_pc[i]));
                    if (m_xf[i] == 0) first_pc[i] = ipc[i];
                    m_exp_pc[i] = m_exp_pc[i] + 32'd4;
                    m_xf[i]++;
                    xcnt[i]++;
                end
                if (val[i] && !rdy) m_st[i]++;
                if (rv) m_exp_pc[i] = {rpc[31:2], 2'b00};
                m_prev_valid[i] = val[i];
                m_prev_instr[i] = ins[i];
                m_prev_ipc[i]   = ipc[i];
            end
        end
        m_prev_rst      = rst;
        m_prev_ready    = rdy;
        m_prev_redirect = rv && !rst;
        m_prev_target   = {rpc[31:2], 2'b00};
        cyc = rst ? 0 : cyc + 1;
        @(posedge clk);
        #1;
        a_rdata = req[0] ? mem_word(addr[0]) : $urandom();
        b_rdata = req[1] ? mem_word(addr[1]) : $urandom();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle(1'b0, 1'b0, 32'h0);
        rst = 1'b0;
    endtask

    task automatic run_until_xfer(input int i, input string tag, input logic [31:0] exp);
        int start;
        int n;
        start = xcnt[i];
        n = 0;
        while (xcnt[i] == start && n < 20) begin
            cycle(1'b1, 1'b0, 32'h0);
            n++;
        end
        check(tag, (xcnt[i] == start) ? NO_XFER : m_exp_pc[i] - 32'd4, exp);
    endtask

    initial begin
        int issued_a;
        int issued_b;
        int k;
        salt = $urandom();
        m_prev_rst = 1'b0; m_prev_ready = 1'b0; m_prev_redirect = 1'b0; m_prev_target = 32'h0;
        cyc = 0;
        for (int i = 0; i < 2; i++) begin
            xcnt[i] = 0; m_xf[i] = 0; m_st[i] = 0; m_prev_valid[i] = 1'b0;
        end

        // Reset release with ready held high: sequential issue, 2-cycle latency, 1/cycle.
        do_reset();
        repeat (8) cycle(1'b1, 1'b0, 32'h0);
        check("boot_no_req", {31'b0, lg_req[0][0]}, 32'h0);
        check("first_req", {31'b0, lg_req[0][1]}, 32'h1);
        check("addr_c1", lg_addr[0][1], 32'h100);
        check("addr_c2", lg_addr[0][2], 32'h104);
        check("addr_c3", lg_addr[0][3], 32'h108);
        check("valid_c2_low", {31'b0, lg_valid[0][2]}, 32'h0);
        check("valid_c3_high", {31'b0, lg_valid[0][3]}, 32'h1);
        check("pc_c3", lg_pc[0][3], 32'h100);
        check("pc_c4", lg_pc[0][4], 32'h104);
        for (int c = 4; c < 8; c++) check("throughput_valid", {31'b0, lg_valid[0][c]}, 32'h1);
        check("wrap_pc0", lg_pc[1][3], 32'hFFFF_FFF8);
        check("wrap_pc1", lg_pc[1][4], 32'hFFFF_FFFC);
        check("wrap_pc2", lg_pc[1][5], 32'h0000_0000);

        // Decode stalled for five cycles after the first valid.
        do_reset();
        repeat (8) cycle(1'b0, 1'b0, 32'h0);
        issued_a = 0;
        issued_b = 0;
        for (int c = 0; c < 8; c++) begin
            issued_a += int'(lg_req[0][c]);
            issued_b += int'(lg_req[1][c]);
        end
        check("stall_outstanding_a", {31'b0, issued_a <= DEPTH_A}, 32'h1);
        check("stall_outstanding_b", {31'b0, issued_b <= DEPTH_B}, 32'h1);
        repeat (2) cycle(1'b1, 1'b0, 32'h0);
        check("stall_release_pc0", lg_pc[0][8], 32'h100);
        check("stall_release_valid1", {31'b0, lg_valid[0][9]}, 32'h1);
        check("stall_release_pc1", lg_pc[0][9], 32'h104);

        // Redirect while 0x10C is being fetched.
        do_reset();
        repeat (4) cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 32'h200);
        check("redir_during_10c", lg_addr[0][4], 32'h10C);
        run_until_xfer(0, "redir_first_pc", 32'h200);
        check("redir_valid_n1", {31'b0, lg_valid[0][5]}, 32'h0);
        check("redir_addr_n1", lg_addr[0][5], 32'h200);

        // Back-to-back redirects: the later target wins.
        k = cyc;
        cycle(1'b1, 1'b1, 32'h202);
        cycle(1'b1, 1'b1, 32'h300);
        run_until_xfer(0, "double_redir_first_pc", 32'h300);
        check("double_redir_addr0", lg_addr[0][k + 1], 32'h200);
        check("double_redir_addr1", lg_addr[0][k + 2], 32'h300);

        // PC wrap reached through a redirect on the small instance.
        cycle(1'b1, 1'b1, 32'hFFFF_FFF8);
        run_until_xfer(0, "redir_wrap0", 32'hFFFF_FFF8);
        run_until_xfer(0, "redir_wrap1", 32'hFFFF_FFFC);
        run_until_xfer(0, "redir_wrap2", 32'h0000_0000);

        // Reset with two buffered and one in flight (deep instance).
        do_reset();
        repeat (4) cycle(1'b0, 1'b0, 32'h0);
        check("pre_reset_b_valid", {31'b0, lg_valid[1][3]}, 32'h1);
        check("pre_reset_b_req", {31'b0, lg_req[1][3]}, 32'h1);
        do_reset();
        repeat (5) cycle(1'b1, 1'b0, 32'h0);
        check("post_reset_first_a", first_pc[0], PC_A);
        check("post_reset_first_b", first_pc[1], PC_B);

        // Random decode back-pressure and redirects.
        repeat (3000) begin
            cycle(($urandom() % 4) != 0, ($urandom() % 20) == 0, $urandom());
        end
        run_until_xfer(0, "final_live_a", m_exp_pc[0]);
        run_until_xfer(1, "final_live_b", m_exp_pc[1]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
